// File: rtl/stopwatch_lap_buffer.sv
// Millisecond stopwatch (up to 59:59.999) with a circular lap memory and a lap review mode.
// Commands are single-cycle pulses; reset_p and clear both return the block to IDLE.
module stopwatch_lap_buffer #(
  parameter int unsigned CLKS_PER_MS = 100000,
  parameter int unsigned LAP_DEPTH   = 8,
  localparam int unsigned IW         = $clog2(LAP_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_p,
  input  logic          start_stop,
  input  logic          lap,
  input  logic          clear,
  output logic [1:0]    state,
  output logic [27:0]   time_bcd,
  output logic [27:0]   view_bcd,
  output logic [IW-1:0] view_idx,
  output logic [IW-1:0] lap_count,
  output logic          lap_full,
  output logic          lap_ovf,
  output logic          time_ovf,
  output logic          ms_tick,
  output logic [15:0]   disp_value
);

  localparam int unsigned PW = $clog2(CLKS_PER_MS);
  localparam int unsigned AW = $clog2(LAP_DEPTH);

  localparam logic [PW-1:0] PresMax  = PW'(CLKS_PER_MS - 1);
  localparam logic [IW-1:0] DepthCnt = IW'(LAP_DEPTH);
  localparam logic [AW-1:0] PtrMax   = AW'(LAP_DEPTH - 1);
  localparam logic [AW:0]   DepthSum = (AW + 1)'(LAP_DEPTH);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StPaused = 2'd2,
    StView   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [27:0]      time_q, time_d;
  logic             time_ovf_q, time_ovf_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [IW-1:0]    lap_count_q, lap_count_d;
  logic             lap_ovf_q, lap_ovf_d;
  logic [IW-1:0]    view_idx_q, view_idx_d;
  logic [27:0]      view_q, view_d;
  logic [27:0]      mem [LAP_DEPTH];
  logic             rec;
  logic             full;
  logic [AW-1:0]    base;
  logic [AW:0]      sum;
  logic [AW-1:0]    phys;

  function automatic logic [3:0] digit_max(input int idx);
    return (idx == 4 || idx == 6) ? 4'd5 : 4'd9;
  endfunction

  assign full = (lap_count_q == DepthCnt);

  // Command FSM; start_stop outranks lap, clear/reset are applied in the state register.
  always_comb begin
    state_d    = state_q;
    view_idx_d = view_idx_q;
    rec        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_stop) state_d = StRun;
      end
      StRun: begin
        if (start_stop) state_d = StPaused;
        else if (lap)   rec = ~(reset_p | clear);
      end
      StPaused: begin
        if (start_stop) begin
          state_d = StRun;
        end else if (lap && lap_count_q != '0) begin
          state_d    = StView;
          view_idx_d = '0;
        end
      end
      StView: begin
        if (start_stop) begin
          state_d    = StPaused;
          view_idx_d = '0;
        end else if (lap) begin
          view_idx_d = (view_idx_q == lap_count_q - IW'(1)) ? '0 : view_idx_q + IW'(1);
        end
      end
    endcase
  end

  assign ms_tick = (state_q == StRun) && (presc_q == PresMax);

  always_comb begin
    presc_d = presc_q;
    if (state_q == StRun) presc_d = ms_tick ? '0 : presc_q + PW'(1);
  end

  // BCD cascade, ms1 upward; carry ripples through all digits in one cycle.
  always_comb begin
    logic carry;
    time_d     = time_q;
    time_ovf_d = time_ovf_q;
    carry      = ms_tick;
    for (int i = 0; i < 7; i++) begin
      if (carry) begin
        if (time_q[4*i +: 4] == digit_max(i)) begin
          time_d[4*i +: 4] = 4'd0;
        end else begin
          time_d[4*i +: 4] = time_q[4*i +: 4] + 4'd1;
          carry            = 1'b0;
        end
      end
    end
    if (carry) time_ovf_d = 1'b1;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    lap_count_d = lap_count_q;
    lap_ovf_d   = lap_ovf_q;
    if (rec) begin
      wr_ptr_d = (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + AW'(1);
      if (full) lap_ovf_d = 1'b1;
      else      lap_count_d = lap_count_q + IW'(1);
    end
  end

  // Once the memory has wrapped, the oldest entry sits at the write pointer.
  assign base = full ? wr_ptr_q : '0;
  assign sum  = (AW + 1)'(base) + (AW + 1)'(view_idx_q);
  assign phys = AW'((sum >= DepthSum) ? sum - DepthSum : sum);

  // Stale memory contents survive clear, so an empty buffer must read as zero.
  assign view_d = (lap_count_q == '0) ? '0 : mem[phys];

  always_ff @(posedge clk) begin
    if (reset_p || clear) begin
      state_q     <= StIdle;
      presc_q     <= '0;
      time_q      <= '0;
      time_ovf_q  <= 1'b0;
      wr_ptr_q    <= '0;
      lap_count_q <= '0;
      lap_ovf_q   <= 1'b0;
      view_idx_q  <= '0;
      view_q      <= '0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      time_q      <= time_d;
      time_ovf_q  <= time_ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      lap_count_q <= lap_count_d;
      lap_ovf_q   <= lap_ovf_d;
      view_idx_q  <= view_idx_d;
      view_q      <= view_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rec) mem[wr_ptr_q] <= time_q;
  end

  assign state      = state_q;
  assign time_bcd   = time_q;
  assign view_bcd   = view_q;
  assign view_idx   = view_idx_q;
  assign lap_count  = lap_count_q;
  assign lap_full   = full;
  assign lap_ovf    = lap_ovf_q;
  assign time_ovf   = time_ovf_q;
  assign disp_value = (state_q == StView) ? view_q[23:8] : time_q[23:8];

endmodule

// File: tb/tb_stopwatch_lap_buffer.sv
// Directed bench for stopwatch_lap_buffer with CLKS_PER_MS=4, LAP_DEPTH=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_stopwatch_lap_buffer;

  localparam int unsigned CPM = 4;
  localparam int unsigned LD  = 4;
  localparam int unsigned IW  = $clog2(LD + 1);

  logic          clk = 1'b0;
  logic          reset_p, start_stop, lap, clear;
  logic [1:0]    state;
  logic [27:0]   time_bcd, view_bcd;
  logic [IW-1:0] view_idx, lap_count;
  logic          lap_full, lap_ovf, time_ovf, ms_tick;
  logic [15:0]   disp_value;

  int n_vec = 0;
  int n_err = 0;
  int tick_cnt = 0;

  stopwatch_lap_buffer #(
    .CLKS_PER_MS(CPM),
    .LAP_DEPTH  (LD)
  ) dut (
    .clk       (clk),
    .reset_p   (reset_p),
    .start_stop(start_stop),
    .lap       (lap),
    .clear     (clear),
    .state     (state),
    .time_bcd  (time_bcd),
    .view_bcd  (view_bcd),
    .view_idx  (view_idx),
    .lap_count (lap_count),
    .lap_full  (lap_full),
    .lap_ovf   (lap_ovf),
    .time_ovf  (time_ovf),
    .ms_tick   (ms_tick),
    .disp_value(disp_value)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ms_tick) tick_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One-cycle command pulse, returning at the falling edge after it was sampled.
  task automatic step(input logic ss, input logic lp, input logic clr, input logic rst);
    start_stop = ss;
    lap        = lp;
    clear      = clr;
    reset_p    = rst;
    @(posedge clk);
    @(negedge clk);
    start_stop = 1'b0;
    lap        = 1'b0;
    clear      = 1'b0;
    reset_p    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct packed {
    logic       ss;
    logic       lp;
    logic       clr;
    logic       rst;
    logic [1:0] st;
    logic [2:0] cnt;
    logic [2:0] idx;
  } cmd_t;

  typedef struct packed {
    logic [2:0]  idx;
    logic [27:0] view;
  } rv_t;

  cmd_t cmds [13];
  rv_t  revs [5];

  initial begin
    //             ss    lp    clr   rst   st    cnt   idx
    cmds[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 3'd0};
    cmds[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 3'd0};  // lap ignored in IDLE
    cmds[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0, 3'd0};
    cmds[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 3'd1, 3'd0};
    cmds[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 3'd1, 3'd0};  // start_stop wins over lap
    cmds[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 3'd1, 3'd0};
    cmds[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 3'd1, 3'd0};  // wraps at lap_count-1
    cmds[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 3'd1, 3'd0};
    cmds[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 3'd0};  // clear wins over start_stop
    cmds[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0, 3'd0};
    cmds[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 3'd0, 3'd0};
    cmds[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 3'd0, 3'd0};  // empty memory: no review
    cmds[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 3'd0, 3'd0};

    revs[0] = '{3'd0, 28'h0000002};
    revs[1] = '{3'd1, 28'h0000003};
    revs[2] = '{3'd2, 28'h0000004};
    revs[3] = '{3'd3, 28'h0000005};
    revs[4] = '{3'd0, 28'h0000002};

    start_stop = 1'b0;
    lap        = 1'b0;
    clear      = 1'b0;
    reset_p    = 1'b1;
    idle(2);
    reset_p = 1'b0;

    check("reset state", 32'(state), 32'd0);
    check("reset time", 32'(time_bcd), 32'd0);
    check("reset view", 32'(view_bcd), 32'd0);
    check("reset lap_count", 32'(lap_count), 32'd0);
    check("reset flags", {28'd0, lap_full, lap_ovf, time_ovf, ms_tick}, 32'd0);

    // Command table
    for (int i = 0; i < 13; i++) begin
      step(cmds[i].ss, cmds[i].lp, cmds[i].clr, cmds[i].rst);
      check($sformatf("cmd[%0d] state", i), 32'(state), 32'(cmds[i].st));
      check($sformatf("cmd[%0d] lap_count", i), 32'(lap_count), 32'(cmds[i].cnt));
      check($sformatf("cmd[%0d] view_idx", i), 32'(view_idx), 32'(cmds[i].idx));
    end
    check("clear+ss time", 32'(time_bcd), 32'd0);

    // One second of running
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    tick_cnt = 0;
    idle(4000);
    check("1s time", 32'(time_bcd), 32'h0001000);
    check("1s ticks", 32'(tick_cnt), 32'd1000);
    check("1s state", 32'(state), 32'd1);
    check("1s disp", 32'(disp_value), 32'h0010);

    // Pause at 10 ms with prescaler phase 2, then resume
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(41);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("pause state", 32'(state), 32'd2);
    check("pause time", 32'(time_bcd), 32'h0000010);
    idle(100);
    check("paused time held", 32'(time_bcd), 32'h0000010);
    check("paused no tick", 32'(ms_tick), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("resume state", 32'(state), 32'd1);
    check("resume no tick yet", 32'(ms_tick), 32'd0);
    idle(1);
    check("resume tick", 32'(ms_tick), 32'd1);
    check("resume time pre", 32'(time_bcd), 32'h0000010);
    idle(1);
    check("resume time post", 32'(time_bcd), 32'h0000011);

    // Five laps at 1..5 ms into a 4-deep memory
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    for (int k = 1; k <= 5; k++) begin
      idle(3);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      check($sformatf("lap%0d count", k), 32'(lap_count), (k > 4) ? 32'd4 : 32'(k));
      check($sformatf("lap%0d full", k), 32'(lap_full), (k >= 4) ? 32'd1 : 32'd0);
      check($sformatf("lap%0d ovf", k), 32'(lap_ovf), (k > 4) ? 32'd1 : 32'd0);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("laps paused", 32'(state), 32'd2);
    check("oldest outside view", 32'(view_bcd), 32'h0000002);
    for (int r = 0; r < 5; r++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      idle(1);
      check($sformatf("review[%0d] state", r), 32'(state), 32'd3);
      check($sformatf("review[%0d] idx", r), 32'(view_idx), 32'(revs[r].idx));
      check($sformatf("review[%0d] view", r), 32'(view_bcd), 32'(revs[r].view));
      check($sformatf("review[%0d] disp", r), 32'(disp_value), 32'(revs[r].view[23:8]));
    end
    check("review time frozen", 32'(time_bcd), 32'h0000005);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("exit review state", 32'(state), 32'd2);
    check("exit review idx", 32'(view_idx), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("re-enter view", 32'(state), 32'd3);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("reset in view state", 32'(state), 32'd0);
    check("reset in view disp", 32'(disp_value), 32'd0);
    check("reset in view laps", {28'd0, lap_full, lap_ovf, 2'b00}, 32'd0);
    check("reset in view count", 32'(lap_count), 32'd0);
    idle(1);
    check("reset in view bcd", 32'(view_bcd), 32'd0);

    // Time wrap from 59:59.998, preloaded while idle
    step(1'b0, 1'b0, 1'b1, 1'b0);
    force dut.time_q = 28'h5959998;
    idle(1);
    release dut.time_q;
    idle(1);
    check("preload time", 32'(time_bcd), 32'h5959998);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    check("59:59.999", 32'(time_bcd), 32'h5959999);
    check("no ovf yet", 32'(time_ovf), 32'd0);
    idle(4);
    check("wrap time", 32'(time_bcd), 32'h0000000);
    check("wrap ovf", 32'(time_ovf), 32'd1);
    idle(4);
    check("after wrap time", 32'(time_bcd), 32'h0000001);
    check("ovf sticky", 32'(time_ovf), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("clear ovf", 32'(time_ovf), 32'd0);
    check("clear time", 32'(time_bcd), 32'd0);
    check("clear state", 32'(state), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
